// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM state codes
// and the default data-memory size.
package lsu_pkg;

   localparam int unsigned MEM_BYTES_DEF = 16384;

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_LOAD   = 3'd1;
   localparam logic [2:0] ST_STORE  = 3'd2;
   localparam logic [2:0] ST_RMW_RD = 3'd3;
   localparam logic [2:0] ST_RMW_WR = 3'd4;
   localparam logic [2:0] ST_DONE   = 3'd5;

   // Byte and half stores need read-modify-write; 2'b11 falls through to word.
   function automatic logic is_subword(input logic [1:0] size);
      return (size == SZ_B) || (size == SZ_H);
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Big-endian lane handling: extracts and extends load results from the MSB
// end of the dmem word, and merges sub-word store data into a read word.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [1:0]  i_size,
   input  logic        i_uns,
   input  logic [31:0] i_rdata,
   input  logic [31:0] i_st_data,
   output logic [31:0] o_ld_ext,
   output logic [31:0] o_merged
);

   logic w_sign_b;
   logic w_sign_h;

   assign w_sign_b = i_rdata[31] & ~i_uns;
   assign w_sign_h = i_rdata[31] & ~i_uns;

   always_comb begin
      o_ld_ext = i_rdata;
      o_merged = i_st_data;
      case (i_size)
         SZ_B: begin
            o_ld_ext = {{24{w_sign_b}}, i_rdata[31:24]};
            o_merged = {i_st_data[7:0], i_rdata[23:0]};
         end
         SZ_H: begin
            o_ld_ext = {{16{w_sign_h}}, i_rdata[31:16]};
            o_merged = {i_st_data[15:0], i_rdata[15:0]};
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer between the core's execute stage and dmem; converts
// byte/half/word accesses into 4-byte big-endian dmem reads and writes.
//
// state     | meaning
// ----------+--------------------------------------------------------
// IDLE      | waiting for req; captures the access
// LOAD      | dmem read, extended result registered into ld_data
// STORE     | full-word dmem write
// RMW_RD    | dmem read, store data merged into the read word
// RMW_WR    | merged word written back
// DONE      | one-cycle completion pulse (err qualifies it)
module lsu_ctrl
   import lsu_pkg::*;
#(
   parameter int unsigned MEM_BYTES = MEM_BYTES_DEF,
   parameter int unsigned AW        = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req,
   input  logic          we,
   input  logic [1:0]    size,
   input  logic          uns,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   st_data,
   output logic [31:0]   ld_data,
   output logic          done,
   output logic          busy,
   output logic          err,
   output logic          dm_rvalid,
   output logic          dm_wvalid,
   output logic [AW-1:0] dm_raddr,
   output logic [AW-1:0] dm_waddr,
   output logic [31:0]   dm_wdata,
   input  logic [31:0]   dm_rdata
);

   logic [2:0]    r_state;
   logic [2:0]    w_next;
   logic [AW-1:0] r_addr;
   logic [1:0]    r_size;
   logic          r_uns;
   logic          r_err;
   logic [31:0]   r_wdata;
   logic [31:0]   r_ld_data;
   logic [AW:0]   w_end;
   logic          w_oor;
   logic [31:0]   w_ld_ext;
   logic [31:0]   w_merged;

   assign w_end = {1'b0, addr} + (AW+1)'(3);
   assign w_oor = w_end >= (AW+1)'(MEM_BYTES);

   lsu_align u_align (
      .i_size    (r_size),
      .i_uns     (r_uns),
      .i_rdata   (dm_rdata),
      .i_st_data (r_wdata),
      .o_ld_ext  (w_ld_ext),
      .o_merged  (w_merged)
   );

   // Out-of-range requests spend one strobe-free cycle in LOAD so every
   // non-RMW completion, including errors, has the same latency.
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (req) begin
               if (w_oor || !we)        w_next = ST_LOAD;
               else if (is_subword(size)) w_next = ST_RMW_RD;
               else                     w_next = ST_STORE;
            end
         end
         ST_LOAD, ST_STORE, ST_RMW_WR: w_next = ST_DONE;
         ST_RMW_RD: w_next = r_err ? ST_DONE : ST_RMW_WR;
         default:   w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= ST_IDLE;
         r_addr    <= '0;
         r_size    <= 2'b00;
         r_uns     <= 1'b0;
         r_err     <= 1'b0;
         r_wdata   <= 32'h0;
         r_ld_data <= 32'h0;
      end else begin
         r_state <= w_next;
         case (r_state)
            ST_IDLE: begin
               if (req) begin
                  r_addr  <= addr;
                  r_size  <= size;
                  r_uns   <= uns;
                  r_err   <= w_oor;
                  r_wdata <= st_data;
               end
            end
            ST_LOAD:   r_ld_data <= r_err ? 32'h0 : w_ld_ext;
            ST_RMW_RD: r_wdata   <= w_merged;
            ST_DONE:   r_err     <= 1'b0;
            default: ;
         endcase
      end
   end

   assign dm_rvalid = ((r_state == ST_LOAD) || (r_state == ST_RMW_RD)) && !r_err;
   assign dm_wvalid = ((r_state == ST_STORE) || (r_state == ST_RMW_WR)) && !r_err;
   assign dm_raddr  = r_addr;
   assign dm_waddr  = r_addr;
   assign dm_wdata  = r_wdata;
   assign ld_data   = r_ld_data;
   assign done      = (r_state == ST_DONE);
   assign err       = (r_state == ST_DONE) && r_err;
   assign busy      = (r_state != ST_IDLE);

endmodule
